// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the render-math blocks (multiplier, divider).
// Format is two's complement with 1 sign bit, FXP_INTEGER integer bits and FXP_DECIMAL fraction bits.
package fxp_pkg;

  localparam int FXP_INTEGER   = 10;
  localparam int FXP_DECIMAL   = 7;
  localparam int FXP_PRECISION = 1 + FXP_INTEGER + FXP_DECIMAL;

  localparam logic [FXP_PRECISION-1:0] FXP_MAX = {1'b0, {(FXP_PRECISION-1){1'b1}}};
  localparam logic [FXP_PRECISION-1:0] FXP_MIN = {1'b1, {(FXP_PRECISION-1){1'b0}}};
  localparam logic [FXP_PRECISION-1:0] FXP_ONE = FXP_PRECISION'(1) << FXP_DECIMAL;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIN,
    DONE
  } mul_state_t;

endpackage

// File: rtl/fxp_multiplier_if.sv
// Operand/result bus of the fixed-point multiplier.
interface fxp_multiplier_if
  import fxp_pkg::*;
#(
  parameter int PRECISION = FXP_PRECISION
);

  // Both channels are valid/ready: a transfer happens on a rising clk edge where
  // valid and ready are both high; the source holds data stable while valid is high
  // and ready is low, and valid never depends combinationally on ready.
  logic                 in_vld;
  logic                 in_rdy;
  logic [PRECISION-1:0] in_a;
  logic [PRECISION-1:0] in_b;
  logic                 out_vld;
  logic                 out_rdy;
  logic [PRECISION-1:0] out_p;
  logic                 out_sat;

  modport master (
    output in_vld, in_a, in_b, out_rdy,
    input  in_rdy, out_vld, out_p, out_sat
  );

  modport slave (
    input  in_vld, in_a, in_b, out_rdy,
    output in_rdy, out_vld, out_p, out_sat
  );

endinterface

// File: rtl/fxp_sat.sv
// Turns an unsigned magnitude plus a sign into a clamped signed fixed-point word.
// A zero magnitude always yields +0; the sat flag marks a clamped result.
module fxp_sat
  import fxp_pkg::*;
#(
  parameter int MAG_W     = 2 * FXP_PRECISION - FXP_DECIMAL,
  parameter int PRECISION = FXP_PRECISION
) (
  input  logic [MAG_W-1:0]     mag,
  input  logic                 sign,
  output logic [PRECISION-1:0] p,
  output logic                 sat
);

  // The negative range reaches one step further than the positive one.
  localparam logic [MAG_W-1:0] POS_LIM = MAG_W'((64'd1 << (PRECISION - 1)) - 64'd1);
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(64'd1 << (PRECISION - 1));

  always_comb begin
    p   = mag[PRECISION-1:0];
    sat = 1'b0;
    if (!sign && (mag > POS_LIM)) begin
      p   = {1'b0, {(PRECISION-1){1'b1}}};
      sat = 1'b1;
    end else if (sign && (mag > NEG_LIM)) begin
      p   = {1'b1, {(PRECISION-1){1'b0}}};
      sat = 1'b1;
    end else if (sign) begin
      p = -mag[PRECISION-1:0];
    end
  end

endmodule

// File: rtl/fxp_multiplier.sv
// Iterative radix-2 shift-add signed fixed-point multiplier; one product every few cycles.
// Works on magnitudes, truncates the fraction (round toward zero) and saturates.
module fxp_multiplier
  import fxp_pkg::*;
#(
  parameter int INTEGER   = FXP_INTEGER,
  parameter int DECIMAL   = FXP_DECIMAL,
  parameter int PRECISION = 1 + INTEGER + DECIMAL
) (
  input  logic               clk,
  input  logic               rst_n,
  fxp_multiplier_if.slave    bus,
  output mul_state_t         dbg_state
);

  localparam int ACC_W = 2 * PRECISION;
  localparam int MAG_W = ACC_W - DECIMAL;
  localparam int CNT_W = $clog2(PRECISION);

  mul_state_t           state, state_nxt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     mcand;
  logic [PRECISION-1:0] mplier;
  logic [CNT_W-1:0]     count;
  logic                 sign;
  logic [PRECISION-1:0] p_reg;
  logic                 sat_reg;
  logic [PRECISION-1:0] mag_a, mag_b;
  logic [PRECISION-1:0] sat_p;
  logic                 sat_flag;

  // -2^(P-1) negates to itself, which read as unsigned is exactly its magnitude.
  assign mag_a = bus.in_a[PRECISION-1] ? -bus.in_a : bus.in_a;
  assign mag_b = bus.in_b[PRECISION-1] ? -bus.in_b : bus.in_b;

  assign bus.in_rdy  = (state == IDLE);
  assign bus.out_vld = (state == DONE);
  assign bus.out_p   = p_reg;
  assign bus.out_sat = sat_reg;
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_vld) state_nxt = BUSY;
      BUSY:    if (count == CNT_W'(PRECISION - 1)) state_nxt = FIN;
      FIN:     state_nxt = DONE;
      DONE:    if (bus.out_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      sign    <= 1'b0;
      p_reg   <= '0;
      sat_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_vld) begin
            acc    <= '0;
            mcand  <= {{PRECISION{1'b0}}, mag_a};
            mplier <= mag_b;
            count  <= '0;
            sign   <= bus.in_a[PRECISION-1] ^ bus.in_b[PRECISION-1];
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          count  <= count + CNT_W'(1);
        end
        FIN: begin
          p_reg   <= sat_p;
          sat_reg <= sat_flag;
        end
        default: ;
      endcase
    end
  end

  fxp_sat #(
    .MAG_W     (MAG_W),
    .PRECISION (PRECISION)
  ) u_sat (
    .mag  (acc[ACC_W-1:DECIMAL]),
    .sign (sign),
    .p    (sat_p),
    .sat  (sat_flag)
  );

endmodule

// File: tb/tb_fxp_multiplier.sv
// Bench for fxp_multiplier: directed corner cases, backpressure, reset, busy-time input
// and a random stream checked against a signed-arithmetic reference.
module tb_fxp_multiplier;
  import fxp_pkg::*;

  localparam int P = FXP_PRECISION;
  localparam int D = FXP_DECIMAL;
  localparam int W = P + 1;
  localparam int RDY_HIGH = 1;
  localparam int RDY_RAND = 2;
  localparam int RDY_LOW  = 3;

  logic       clk;
  logic       rst_n;
  mul_state_t dbg_state;

  fxp_multiplier_if #(.PRECISION(P)) bus ();

  fxp_multiplier #(
    .INTEGER   (FXP_INTEGER),
    .DECIMAL   (D),
    .PRECISION (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         n_retired = 0;
  int         rdy_mode = RDY_HIGH;
  logic [W-1:0] exp_q[$];
  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_val = '0;

  logic [P-1:0] dir_a [9] = '{18'h00140, 18'h3FF40, 18'h00001, 18'h3FFFF, 18'h12C00,
                              18'h2D400, 18'h20000, 18'h30000, 18'h1FFFF};
  logic [P-1:0] dir_b [9] = '{18'h00200, 18'h00100, 18'h00040, 18'h00040, 18'h00100,
                              18'h00100, 18'h3FF80, 18'h00100, 18'h00080};
  logic [P-1:0] dir_p [9] = '{18'h00500, 18'h3FE80, 18'h00000, 18'h00000, 18'h1FFFF,
                              18'h20000, 18'h1FFFF, 18'h20000, 18'h1FFFF};
  logic         dir_s [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed product, divided by 2^D with truncation toward zero, then clamped.
  function automatic logic [W-1:0] model(input logic [P-1:0] a, input logic [P-1:0] b);
    longint sa, sb, q, one, hi, lo;
    logic [63:0] qv;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    one = longint'(1) << D;
    hi  = (longint'(1) << (P - 1)) - 1;
    lo  = -(longint'(1) << (P - 1));
    q   = (sa * sb) / one;
    if (q > hi) q = hi;
    else if (q < lo) q = lo;
    qv = q;
    return {((sa * sb) / one > hi) || ((sa * sb) / one < lo), qv[P-1:0]};
  endfunction

  function automatic logic [P-1:0] rand_op();
    logic [31:0] r;
    logic [P-1:0] v;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: v = r[P-1:0];
      1: v = P'($signed(r[11:0]));
      2: begin
        case ($urandom_range(0, 6))
          0: v = 18'h00000;
          1: v = 18'h1FFFF;
          2: v = 18'h20000;
          3: v = 18'h00080;
          4: v = 18'h3FF80;
          5: v = 18'h00001;
          default: v = 18'h3FFFF;
        endcase
      end
      default: v = P'($signed(r[14:0]));
    endcase
    return v;
  endfunction

  // driver: waits for in_rdy, presents one operand pair for exactly one accepting edge
  task automatic send(input logic [P-1:0] a, input logic [P-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_rdy) begin
      check("in_rdy_timeout", 32'd0, 32'd1);
      return;
    end
    bus.in_vld = 1'b1;
    bus.in_a   = a;
    bus.in_b   = b;
    @(posedge clk);
    exp_q.push_back(model(a, b));
    @(negedge clk);
    bus.in_vld = 1'b0;
    bus.in_a   = rand_op();
    bus.in_b   = rand_op();
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (!bus.out_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_vld) check("out_vld_timeout", 32'd0, 32'd1);
  endtask

  // sink + scoreboard: drives out_rdy, checks hold stability and retired results
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        RDY_HIGH: bus.out_rdy = 1'b1;
        RDY_RAND: bus.out_rdy = ($urandom_range(0, 3) != 0);
        default:  bus.out_rdy = 1'b0;
      endcase
      if (rst_n && hold_pending) begin
        check("hold_vld", 32'(bus.out_vld), 32'd1);
        check("hold_val", 32'({bus.out_sat, bus.out_p}), 32'(hold_val));
      end
      if (rst_n && bus.out_vld && bus.out_rdy) begin
        n_retired++;
        if (exp_q.size() == 0) check("spurious_result", 32'd1, 32'd0);
        else check("result", 32'({bus.out_sat, bus.out_p}), 32'(exp_q.pop_front()));
        hold_pending = 1'b0;
      end else if (rst_n && bus.out_vld) begin
        hold_pending = 1'b1;
        hold_val     = {bus.out_sat, bus.out_p};
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int r0;
    int guard;
    logic [W-1:0] held;
    rst_n      = 1'b0;
    bus.in_vld = 1'b0;
    bus.in_a   = '0;
    bus.in_b   = '0;
    bus.out_rdy = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    check("rst_out_vld", 32'(bus.out_vld), 32'd0);
    check("rst_out_p", 32'(bus.out_p), 32'd0);
    check("rst_out_sat", 32'(bus.out_sat), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      send(dir_a[i], dir_b[i]);
      wait_vld(n);
      if (i == 0) check("latency", n, P + 1);
      check($sformatf("dir%0d_p", i), 32'(bus.out_p), 32'(dir_p[i]));
      check($sformatf("dir%0d_sat", i), 32'(bus.out_sat), 32'(dir_s[i]));
    end

    // backpressure: result must hold for 10 stalled cycles
    @(posedge clk);
    rdy_mode = RDY_LOW;
    send(18'h00280, 18'h3FE00);
    wait_vld(n);
    held = {bus.out_sat, bus.out_p};
    check("bp_value", 32'(held), 32'(model(18'h00280, 18'h3FE00)));
    repeat (10) begin
      @(negedge clk);
      check("bp_vld", 32'(bus.out_vld), 32'd1);
      check("bp_p", 32'({bus.out_sat, bus.out_p}), 32'(held));
      check("bp_in_rdy", 32'(bus.in_rdy), 32'd0);
    end
    @(posedge clk);
    rdy_mode = RDY_HIGH;
    @(negedge clk);
    @(negedge clk);
    check("bp_vld_drop", 32'(bus.out_vld), 32'd0);
    check("bp_in_rdy_back", 32'(bus.in_rdy), 32'd1);

    // operands offered while busy must be ignored
    send(18'h3FD80, 18'h00380);
    for (int i = 0; i < 15; i++) begin
      check("busy_in_rdy", 32'(bus.in_rdy), 32'd0);
      bus.in_vld = 1'b1;
      bus.in_a   = rand_op();
      bus.in_b   = rand_op();
      @(negedge clk);
    end
    bus.in_vld = 1'b0;
    wait_vld(n);
    check("busy_ignore", 32'({bus.out_sat, bus.out_p}), 32'(model(18'h3FD80, 18'h00380)));

    // reset in the middle of BUSY discards the operation
    send(18'h00300, 18'h00280);
    repeat (5) @(negedge clk);
    check("pre_rst_state", 32'(dbg_state), 32'(BUSY));
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    check("mid_rst_out_vld", 32'(bus.out_vld), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    void'(exp_q.pop_back());
    r0 = n_retired;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_result", n_retired, r0);
    check("rst_idle_vld", 32'(bus.out_vld), 32'd0);

    // random stream with random backpressure
    @(posedge clk);
    rdy_mode = RDY_RAND;
    for (int i = 0; i < 1000; i++) send(rand_op(), rand_op());
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    rdy_mode = RDY_HIGH;
    repeat (5) @(negedge clk);
    check("final_out_vld", 32'(bus.out_vld), 32'd0);
    check("final_in_rdy", 32'(bus.in_rdy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
